// File: rtl/svc_rst_seq.sv
// Multi-channel reset sequencer: holds all channel resets for HOLD_CYCLES, then
// releases them one by one every STAGGER_CYCLES; software can re-run the sequence.
module svc_rst_seq #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned COUNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_CH-1:0]  ch_rst,
  output logic               ready,
  output logic [COUNT_W-1:0] rst_count
);

  localparam int unsigned MaxCnt = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0]    HoldLast  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]    StagLast  = CntW'(STAGGER_CYCLES - 1);
  localparam logic [CntW-1:0]    CntOne    = CntW'(1);
  localparam logic [COUNT_W-1:0] CountOne  = COUNT_W'(1);

  typedef enum logic [1:0] {StAssert, StRelease, StReady} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            sw_pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StAssert;
      cnt_q        <= '0;
      ch_rst       <= '1;
      ready        <= 1'b0;
      sw_rst_ack   <= 1'b0;
      rst_count    <= '0;
      sw_pending_q <= 1'b0;
    end else if (sw_rst_req) begin
      // A request in any state restarts the hold and re-asserts every channel.
      state_q      <= StAssert;
      cnt_q        <= '0;
      ch_rst       <= '1;
      ready        <= 1'b0;
      sw_rst_ack   <= 1'b0;
      sw_pending_q <= 1'b1;
    end else begin
      sw_rst_ack <= 1'b0;
      unique case (state_q)
        StAssert: begin
          if (cnt_q == HoldLast) begin
            state_q <= StRelease;
            cnt_q   <= '0;
            ch_rst  <= ch_rst << 1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StRelease: begin
          // Zeros shift in from bit 0, so bit k is released k-th.
          if (ch_rst == '0) begin
            state_q      <= StReady;
            ready        <= 1'b1;
            sw_rst_ack   <= sw_pending_q;
            sw_pending_q <= 1'b0;
            if (rst_count != '1) begin
              rst_count <= rst_count + CountOne;
            end
          end else if (cnt_q == StagLast) begin
            cnt_q  <= '0;
            ch_rst <= ch_rst << 1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StReady: begin
          state_q <= StReady;
        end
        default: begin
          state_q <= StAssert;
          cnt_q   <= '0;
          ch_rst  <= '1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule
